// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and default baud divisor for the fifo-draining UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;
  localparam int CLKS_PER_BIT_DEF = 868;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter; tick marks the last cycle of each period, clear holds it at zero
module baud_tick_gen import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = !clear && cnt_q == W'(CLKS_PER_BIT - 1);
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read fifo and sends each as an 8N1 LSB-first UART frame on tx
//   in : clk, rst (sync, active high), enable, fifo_empty, fifo_dout[DATA_W-1:0]
//   out: fifo_rd (one-cycle pop), tx (registered, idle high), busy, tx_done (last STOP cycle)
//   UART_PARITY_EN adds an even-parity bit between DATA and STOP
module fifo_uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);
  localparam int BW = $clog2(DATA_W);
  state_e            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d, tick, go;
`ifdef UART_PARITY_EN
  logic              par_q, par_d;
`endif
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE || state_q == POP || state_q == LOAD),
    .tick (tick)
  );
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    go        = enable && !fifo_empty;
`ifdef UART_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE:  state_d = go ? POP : IDLE;
      POP:   state_d = LOAD;
      LOAD: begin
        shift_d = fifo_dout;
        state_d = START;
`ifdef UART_PARITY_EN
        par_d   = ^fifo_dout;
`endif
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(DATA_W - 1)) begin
          bit_cnt_d = '0;
`ifdef UART_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: state_d = tick ? STOP : PARITY;
`endif
      STOP:  state_d = tick ? (go ? POP : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
    // tx is driven from the next state so the registered line lines up with state_q
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA  ? shift_d[0] :
`ifdef UART_PARITY_EN
           state_d == PARITY ? par_q :
`endif
           1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end
  assign tx      = tx_q;
  assign fifo_rd = state_q == POP && !rst;
  assign busy    = state_q != IDLE;
  assign tx_done = state_q == STOP && tick;
endmodule
